spi_master_burst_sequencer: RTL and testbench

Transaction sequencer that sits directly upstream of `SPI_FPGA_MASTER` and feeds it byte-wide packets from a TX FIFO. It drives the master's launch/data inputs and watches its CS and action-done outputs. Each received packet is returned to the user side through a ready/valid RX path. It turns single-shot master launches into back-to-back bursts, with inter-packet gap control and a timeout watchdog.

---
 rtl/spi_master_burst_sequencer.sv | 122 ++++++++++++
 tb/tb_spi_master_burst_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_burst_sequencer.sv
// spi_master_burst_sequencer: feeds SPI_FPGA_MASTER back-to-back launches from a TX FIFO with gap control and a watchdog.
// Define SPI_SEQ_RX_FIFO_EN to replace the single RX register with an RX FIFO.
module spi_master_burst_sequencer #(
  parameter int PACK_LENGTH      = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int LAUNCH_HOLD_CLKS = 5,
  parameter int GAP_CLKS         = 4,
  parameter int TIMEOUT_CLKS     = 1024
) (
  input  logic                   IN_CLOCK,
  input  logic                   IN_RESET_N,
  input  logic [PACK_LENGTH-1:0] IN_TX_DATA,
  input  logic                   IN_TX_VALID,
  output logic                   OUT_TX_READY,
  output logic [PACK_LENGTH-1:0] OUT_RX_DATA,
  output logic                   OUT_RX_VALID,
  input  logic                   IN_RX_READY,
  output logic                   OUT_LAUNCH,
  output logic [PACK_LENGTH-1:0] OUT_MASTER_DATA,
  input  logic                   IN_CS,
  input  logic [PACK_LENGTH-1:0] IN_MASTER_RECEIVE_DATA,
  input  logic                   IN_MASTER_ACTION_DONE,
  output logic                   OUT_BUSY,
  output logic                   OUT_ERROR
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CLKS + LAUNCH_HOLD_CLKS + GAP_CLKS) + 1;
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_HOLD, S_BUSY, S_GAP} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_done_q, r_error;
  logic [PACK_LENGTH-1:0] r_tx_mem [FIFO_DEPTH];
  logic [AW:0] r_tx_wp, r_tx_rp;
  logic [PACK_LENGTH-1:0] r_master_data;
  logic w_tx_full, w_tx_empty, w_rx_room, w_pop, w_push, w_done_edge, w_capture, w_timeout;
  assign w_tx_empty = r_tx_wp == r_tx_rp;
  assign w_tx_full = (r_tx_wp ^ r_tx_rp) == {1'b1, {AW{1'b0}}};
  assign w_pop = r_state == S_IDLE && !w_tx_empty && w_rx_room && IN_CS;
  // A pop in the same cycle frees the slot, so a write into a full FIFO is still taken.
  assign OUT_TX_READY = !w_tx_full || w_pop;
  assign w_push = IN_TX_VALID && OUT_TX_READY;
  assign w_done_edge = IN_MASTER_ACTION_DONE && !r_done_q;
  assign w_capture = r_state == S_BUSY && w_done_edge;
  assign w_timeout = ((r_state == S_LAUNCH && IN_CS) || (r_state == S_BUSY && !w_done_edge))
                     && r_cnt == CW'(TIMEOUT_CLKS - 1);
  assign OUT_MASTER_DATA = r_master_data;
  assign OUT_ERROR = r_error;
  always_comb begin
    w_next = r_state;
    OUT_LAUNCH = r_state == S_LAUNCH || r_state == S_HOLD;
    OUT_BUSY = r_state != S_IDLE;
    case (r_state)
      S_IDLE:   w_next = w_pop ? S_LAUNCH : S_IDLE;
      S_LAUNCH: w_next = !IN_CS ? S_HOLD : w_timeout ? S_GAP : S_LAUNCH;
      S_HOLD:   w_next = r_cnt == CW'(LAUNCH_HOLD_CLKS - 1) ? S_BUSY : S_HOLD;
      S_BUSY:   w_next = (w_capture || w_timeout) ? S_GAP : S_BUSY;
      S_GAP:    w_next = (IN_CS && r_cnt == CW'(GAP_CLKS - 1)) ? S_IDLE : S_GAP;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N)
    if (!IN_RESET_N) r_state <= S_IDLE;
    else r_state <= w_next;
  // One counter serves hold, gap and watchdog; it restarts on every state entry and pauses in GAP while CS is low.
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N)
    if (!IN_RESET_N) begin
      r_cnt <= '0;
      r_done_q <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_cnt <= (w_next != r_state) ? '0 : (r_state != S_GAP || IN_CS) ? r_cnt + 1'b1 : r_cnt;
      r_done_q <= IN_MASTER_ACTION_DONE;
      if (w_timeout) r_error <= 1'b1;
    end
  always_ff @(posedge IN_CLOCK)
    if (w_push) r_tx_mem[r_tx_wp[AW-1:0]] <= IN_TX_DATA;
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N)
    if (!IN_RESET_N) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_master_data <= '0;
    end else begin
      if (w_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_pop) begin
        r_master_data <= r_tx_mem[r_tx_rp[AW-1:0]];
        r_tx_rp <= r_tx_rp + 1'b1;
      end
    end
`ifdef SPI_SEQ_RX_FIFO_EN
  logic [PACK_LENGTH-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW:0] r_rx_wp, r_rx_rp;
  assign w_rx_room = (r_rx_wp ^ r_rx_rp) != {1'b1, {AW{1'b0}}};
  assign OUT_RX_VALID = r_rx_wp != r_rx_rp;
  assign OUT_RX_DATA = r_rx_mem[r_rx_rp[AW-1:0]];
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N)
    if (!IN_RESET_N) begin
      r_rx_wp <= '0;
      r_rx_rp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_rx_mem[i] <= '0;
    end else begin
      if (w_capture) begin
        r_rx_mem[r_rx_wp[AW-1:0]] <= IN_MASTER_RECEIVE_DATA;
        r_rx_wp <= r_rx_wp + 1'b1;
      end
      if (OUT_RX_VALID && IN_RX_READY) r_rx_rp <= r_rx_rp + 1'b1;
    end
`else
  logic [PACK_LENGTH-1:0] r_rx_data;
  logic r_rx_valid;
  assign w_rx_room = !r_rx_valid;
  assign OUT_RX_VALID = r_rx_valid;
  assign OUT_RX_DATA = r_rx_data;
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N)
    if (!IN_RESET_N) begin
      r_rx_data <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_capture) begin
      r_rx_data <= IN_MASTER_RECEIVE_DATA;
      r_rx_valid <= 1'b1;
    end else if (IN_RX_READY) r_rx_valid <= 1'b0;
`endif
endmodule

// File: tb/tb_spi_master_burst_sequencer.sv
// tb_spi_master_burst_sequencer: directed bench with a behavioural SPI master/slave and a TX->RX scoreboard.
module tb_spi_master_burst_sequencer;
  localparam int GAP = 4;
  localparam int TO = 1024;
`ifdef SPI_SEQ_RX_FIFO_EN
  localparam int BP_XFERS = 4;
`else
  localparam int BP_XFERS = 1;
`endif
  logic clk = 1'b0, rst_n, tx_valid, rx_ready, cs_force, cs;
  logic [7:0] tx_data, o_rx_data, o_master_data, m_rxd;
  logic o_tx_ready, o_rx_valid, o_launch, o_busy, o_error, m_cs, m_done, sclk;
  int checks = 0, errors = 0;
  logic [7:0] exp_mosi[$], exp_rx[$], obs_mosi[$], obs_rx[$], slave_q[$];
  int gap_q[$], launch_q[$];
  int xfers = 0, rx_seen = 0, hi_run = 0, lrun = 0;
  logic cs_prev = 1'b1;
  int m_st, m_cnt, m_bit;
  logic [7:0] m_tx, m_rx, s_tx, s_rx, s_last;
  always #5 clk = ~clk;
  assign cs = cs_force | m_cs;
  assign sclk = m_st == 2 && m_cnt >= 2;
  spi_master_burst_sequencer #(.PACK_LENGTH(8), .FIFO_DEPTH(4), .LAUNCH_HOLD_CLKS(5),
    .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)) dut (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_TX_DATA(tx_data), .IN_TX_VALID(tx_valid),
    .OUT_TX_READY(o_tx_ready), .OUT_RX_DATA(o_rx_data), .OUT_RX_VALID(o_rx_valid),
    .IN_RX_READY(rx_ready), .OUT_LAUNCH(o_launch), .OUT_MASTER_DATA(o_master_data),
    .IN_CS(cs), .IN_MASTER_RECEIVE_DATA(m_rxd), .IN_MASTER_ACTION_DONE(m_done),
    .OUT_BUSY(o_busy), .OUT_ERROR(o_error));
  // Master + slave: 8 SCLK periods of 4 clocks, full-duplex exchange, done level raised at the end.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_st <= 0; m_cs <= 1'b1; m_done <= 1'b0; m_cnt <= 0; m_bit <= 0; s_last <= 8'h00; m_rxd <= 8'h00;
    end else case (m_st)
      0: if (o_launch && !cs_force) begin m_done <= 1'b0; m_st <= 1; end
      1: begin
        m_cs <= 1'b0; m_tx <= o_master_data;
        s_tx <= slave_q.size() != 0 ? slave_q.pop_front() : s_last;
        m_cnt <= 0; m_bit <= 0; m_st <= 2;
      end
      2: begin
        m_cnt <= (m_cnt + 1) % 4;
        if (m_cnt == 3) begin
          m_rx <= {m_rx[6:0], s_tx[7]}; s_tx <= {s_tx[6:0], 1'b0};
          s_rx <= {s_rx[6:0], m_tx[7]}; m_tx <= {m_tx[6:0], 1'b0};
          m_bit <= m_bit + 1;
          if (m_bit == 7) m_st <= 3;
        end
      end
      default: begin
        m_cs <= 1'b1; m_done <= 1'b1; m_rxd <= m_rx; s_last <= s_rx;
        obs_mosi.push_back(s_rx); xfers <= xfers + 1; m_st <= 0;
      end
    endcase
  always @(negedge clk) begin
    if (cs) hi_run <= hi_run + 1;
    else begin
      if (cs_prev) gap_q.push_back(hi_run);
      hi_run <= 0;
    end
    cs_prev <= cs;
    if (o_launch) lrun <= lrun + 1;
    else begin
      if (lrun != 0) launch_q.push_back(lrun);
      lrun <= 0;
    end
    if (o_rx_valid && rx_ready) obs_rx.push_back(o_rx_data);
    if (o_rx_valid) rx_seen <= rx_seen + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string p);
    chk({p, "_launch"}, 32'(o_launch), 0);
    chk({p, "_master_data"}, 32'(o_master_data), 0);
    chk({p, "_rx_valid"}, 32'(o_rx_valid), 0);
    chk({p, "_rx_data"}, 32'(o_rx_data), 0);
    chk({p, "_busy"}, 32'(o_busy), 0);
    chk({p, "_error"}, 32'(o_error), 0);
    chk({p, "_tx_ready"}, 32'(o_tx_ready), 1);
  endtask
  task automatic tx_write(input logic [7:0] d);
    tx_data = d; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
  endtask
  task automatic wait_ready(input int lim);
    for (int i = 0; i < lim && !o_tx_ready; i++) begin @(posedge clk); #1; end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 300 && o_busy; i++) begin @(posedge clk); #1; end
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 5000 && (obs_rx.size() < exp_rx.size() || obs_mosi.size() < exp_mosi.size()); i++)
      @(negedge clk);
    chk({tag, "_rx_count"}, obs_rx.size(), exp_rx.size());
    chk({tag, "_mosi_count"}, obs_mosi.size(), exp_mosi.size());
    while (obs_rx.size() != 0 && exp_rx.size() != 0) chk({tag, "_rx"}, 32'(obs_rx.pop_front()), 32'(exp_rx.pop_front()));
    while (obs_mosi.size() != 0 && exp_mosi.size() != 0) chk({tag, "_mosi"}, 32'(obs_mosi.pop_front()), 32'(exp_mosi.pop_front()));
    obs_rx.delete(); exp_rx.delete(); obs_mosi.delete(); exp_mosi.delete();
    @(posedge clk); #1;
  endtask
  task automatic single_byte(input string tag);
    slave_q.push_back(8'h53); exp_mosi.push_back(8'hEA); exp_rx.push_back(8'h53);
    tx_write(8'hEA);
    chk({tag, "_lat1_launch"}, 32'(o_launch), 0);
    @(posedge clk); #1;
    chk({tag, "_lat2_launch"}, 32'(o_launch), 1);
    chk({tag, "_master_data"}, 32'(o_master_data), 'hEA);
    drain(tag);
    wait_idle();
    chk({tag, "_busy_end"}, 32'(o_busy), 0);
    chk({tag, "_error_end"}, 32'(o_error), 0);
  endtask
  initial begin
    int gbase, xbase, lbase, rxs, sent;
    logic [7:0] b;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b1; cs_force = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    single_byte("single");
    // Burst with the slave echoing the previous byte it received.
    gbase = gap_q.size();
    for (int k = 1; k <= 4; k++) begin
      exp_mosi.push_back(8'(k)); exp_rx.push_back(k == 1 ? 8'hEA : 8'(k - 1));
      tx_write(8'(k));
    end
    drain("burst");
    wait_idle();
    chk("burst_cs_windows", gap_q.size() - gbase, 4);
    for (int k = gbase; k < gap_q.size(); k++) chk("burst_gap_ge_min", 32'(gap_q[k] >= GAP), 1);
    // RX backpressure.
    rx_ready = 1'b0; xbase = xfers; sent = 0;
    for (int k = 0; k < 6; k++) begin
      wait_ready(200);
      if (!o_tx_ready) break;
      b = 8'(16 + k);
      exp_mosi.push_back(b); exp_rx.push_back(k == 0 ? 8'h04 : 8'(15 + k));
      tx_write(b); sent++;
    end
    repeat (300) @(posedge clk);
    #1 chk("bp_xfers", xfers - xbase, BP_XFERS);
    chk("bp_launch_low", 32'(o_launch), 0);
    chk("bp_idle", 32'(o_busy), 0);
    chk("bp_rx_valid", 32'(o_rx_valid), 1);
    rx_ready = 1'b1;
    for (int k = sent; k < 6; k++) begin
      wait_ready(3000);
      b = 8'(16 + k);
      exp_mosi.push_back(b); exp_rx.push_back(8'(15 + k));
      tx_write(b);
    end
    drain("bp");
    wait_idle();
    // TX full and watchdog with CS held high.
    cs_force = 1'b1; lbase = launch_q.size(); rxs = rx_seen;
    tx_write(8'hC0);
    repeat (3) @(posedge clk);
    #1 chk("to_launch_high", 32'(o_launch), 1);
    for (int k = 0; k < 4; k++) begin
      tx_write(8'(8'hD0 + k));
      if (k == 2) chk("full_ready_after3", 32'(o_tx_ready), 1);
    end
    chk("full_ready_after4", 32'(o_tx_ready), 0);
    tx_write(8'hD4);
    chk("full_ready_after5", 32'(o_tx_ready), 0);
    for (int i = 0; i < 1500 && launch_q.size() <= lbase; i++) begin @(posedge clk); #1; end
    chk("to_first_done", 32'(launch_q.size() > lbase), 1);
    if (launch_q.size() > lbase) chk("to_launch_len", launch_q[lbase], TO);
    chk("to_error_set", 32'(o_error), 1);
    for (int i = 0; i < 6000 && launch_q.size() < lbase + 5; i++) begin @(posedge clk); #1; end
    repeat (20) @(posedge clk);
    #1 chk("to_launch_count", launch_q.size() - lbase, 5);
    chk("to_idle_after_drop", 32'(o_busy), 0);
    chk("to_launch_low", 32'(o_launch), 0);
    chk("to_error_sticky", 32'(o_error), 1);
    chk("to_no_rx", rx_seen - rxs, 0);
    chk("to_tx_empty_ready", 32'(o_tx_ready), 1);
    // Asynchronous reset during the third SCLK.
    cs_force = 1'b0;
    slave_q.push_back(8'h99);
    tx_write(8'h3C);
    for (int i = 0; i < 300 && !(m_st == 2 && m_bit == 2 && m_cnt == 2); i++) begin @(posedge clk); #1; end
    chk("midrst_sclk", 32'(sclk), 1);
    chk("midrst_busy", 32'(o_busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    slave_q.delete(); obs_mosi.delete(); obs_rx.delete(); exp_mosi.delete(); exp_rx.delete();
    @(posedge clk); #1;
    single_byte("post_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
